dbf_scan_ctrl: RTL

- Per-scanline sequencer for the receive digital beamformer channel bank.
- Drives the shared delay-LUT load bus (address/write strobe), transmit window (tx_en) and receive window (start) common to all DBF channels.
- Walks each scanline through LUT load, transmit, receive and guard gap for a full frame of NUM_LINES lines, then reports frame completion.
- Sits between the system/frame controller and the DBF channel array.

---
 rtl/dbf_scan_ctrl_pkg.sv | 28 ++
 rtl/dbf_phase_cnt.sv | 32 +++
 rtl/dbf_scan_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dbf_scan_ctrl_pkg.sv
// Shared definitions for the DBF scanline sequencer.
// Default phase lengths, bus widths and FSM state encoding.
package dbf_scan_ctrl_pkg;

    localparam int DEF_ADDR_WD    = 9;
    localparam int DEF_LUT_DEPTH  = 512;
    localparam int DEF_TX_CYCLES  = 64;
    localparam int DEF_RX_SAMPLES = 2048;
    localparam int DEF_GAP_CYCLES = 16;
    localparam int DEF_NUM_LINES  = 128;
    localparam int DEF_LINE_WD    = 8;
    localparam int DEF_CNT_WD     = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_TX   = 3'd2,
        ST_RX   = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Down-counter reload value for a phase of len cycles.
    function automatic int phase_ld(input int len);
        return (len > 0) ? len - 1 : 0;
    endfunction

endpackage

// File: rtl/dbf_phase_cnt.sv
// Loadable down-counter shared by all sequencer phases.
// Stops at zero; tc flags the last cycle of the programmed phase.
module dbf_phase_cnt #(
    parameter int CNT_WD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [CNT_WD-1:0] load_val,
    input  logic              dec,
    output logic              tc
);

    logic [CNT_WD-1:0] cnt_q;

    // Clear wins over load, load wins over decrement; no wrap below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WD'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/dbf_scan_ctrl.sv
// Per-scanline sequencer for the receive DBF channel bank.
// Steps every line through LUT load, TX, RX and guard gap.
module dbf_scan_ctrl
    import dbf_scan_ctrl_pkg::*;
#(
    parameter int ADDR_WD    = DEF_ADDR_WD,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH,
    parameter int TX_CYCLES  = DEF_TX_CYCLES,
    parameter int RX_SAMPLES = DEF_RX_SAMPLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WD    = DEF_LINE_WD,
    parameter int CNT_WD     = DEF_CNT_WD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_go,
    input  logic               abort,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               tx_en,
    output logic               start,
    output logic [LINE_WD-1:0] line_idx,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [CNT_WD-1:0] LD_LOAD = CNT_WD'(phase_ld(LUT_DEPTH));
    localparam logic [CNT_WD-1:0] LD_TX   = CNT_WD'(phase_ld(TX_CYCLES));
    localparam logic [CNT_WD-1:0] LD_RX   = CNT_WD'(phase_ld(RX_SAMPLES));
    localparam logic [CNT_WD-1:0] LD_GAP  = CNT_WD'(phase_ld(GAP_CYCLES));
    localparam logic [LINE_WD-1:0] LAST_LINE = LINE_WD'(NUM_LINES - 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_WD-1:0] addr_d;
    logic [LINE_WD-1:0] line_d;
    logic               we_d;
    logic               tx_d;
    logic               st_d;
    logic               fd_d;
    logic               busy_d;
    logic               line_end;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_WD-1:0]  cnt_val;
    logic               cnt_tc;

    dbf_phase_cnt #(
        .CNT_WD (CNT_WD)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // Next state and next registered outputs; entering a phase
    // reloads the shared counter with that phase's length minus one.
    always_comb begin
        state_d  = state_q;
        addr_d   = '0;
        line_d   = line_idx;
        we_d     = 1'b0;
        tx_d     = 1'b0;
        st_d     = 1'b0;
        fd_d     = 1'b0;
        line_end = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (abort) begin
            state_d = ST_IDLE;
            line_d  = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    line_d = '0;
                    if (scan_go) begin
                        state_d  = ST_LOAD;
                        we_d     = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = LD_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt_tc) begin
                        state_d  = ST_TX;
                        tx_d     = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = LD_TX;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = dbf_lut_addr + ADDR_WD'(1);
                        cnt_dec = 1'b1;
                    end
                end
                ST_TX: begin
                    if (cnt_tc) begin
                        state_d  = ST_RX;
                        st_d     = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = LD_RX;
                    end else begin
                        tx_d    = 1'b1;
                        cnt_dec = 1'b1;
                    end
                end
                ST_RX: begin
                    if (cnt_tc) begin
                        if (HAS_GAP) begin
                            state_d  = ST_GAP;
                            cnt_load = 1'b1;
                            cnt_val  = LD_GAP;
                        end else begin
                            line_end = 1'b1;
                        end
                    end else begin
                        st_d    = 1'b1;
                        cnt_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_tc) begin
                        line_end = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    line_d  = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    line_d  = '0;
                end
            endcase
            if (line_end) begin
                if (line_idx == LAST_LINE) begin
                    state_d = ST_DONE;
                    fd_d    = 1'b1;
                end else begin
                    state_d  = ST_LOAD;
                    line_d   = line_idx + LINE_WD'(1);
                    we_d     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = LD_LOAD;
                end
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            line_idx     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbf_lut_addr <= addr_d;
            dbf_lut_we   <= we_d;
            tx_en        <= tx_d;
            start        <= st_d;
            line_idx     <= line_d;
            busy         <= busy_d;
            frame_done   <= fd_d;
        end
    end

endmodule
